// File: rtl/pf_lpddr3_dll_ctrl_pkg.sv
// Shared types and defaults for the LPDDR3 DLL sequencing controller.
// Counter widths are sized so each counter can hold its largest compared value.
package pf_lpddr3_dll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_WAIT_LOCK,
    ST_UPDATE,
    ST_TRACK,
    ST_ERROR
  } dll_state_e;

  localparam int unsigned CODE_W            = 8;
  localparam int unsigned DEF_PWRUP_CYCLES  = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
  localparam int unsigned DEF_LOCK_FILTER   = 8;
  localparam int unsigned DEF_UPDATE_PERIOD = 1024;
  localparam int unsigned DEF_UPDATE_PULSE  = 4;

  // Bits needed to represent values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pf_lpddr3_dll_sync.sv
// Two-flop synchroniser for asynchronous status bits coming back from the DLL.
module pf_lpddr3_dll_sync #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pf_lpddr3_dll_ctrl.sv
// LPDDR3 PHY DLL sequencer: power-up, lock qualification, periodic/requested
// code updates gated by memory-controller hold, lock-loss and timeout handling.
module pf_lpddr3_dll_ctrl
  import pf_lpddr3_dll_ctrl_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES  = DEF_PWRUP_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_FILTER   = DEF_LOCK_FILTER,
  parameter int unsigned UPDATE_PERIOD = DEF_UPDATE_PERIOD,
  parameter int unsigned UPDATE_PULSE  = DEF_UPDATE_PULSE
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CTRL_EN,
  input  logic              UPDATE_REQ,
  input  logic              UPDATE_HOLD,
  input  logic              DLL_LOCK,
  input  logic              DLL_DELAY_DIFF,
  input  logic [CODE_W-1:0] DLL_CODE,
  output logic              DLL_POWERDOWN_N,
  output logic              DLL_CODE_UPDATE,
  output logic              READY,
  output logic [CODE_W-1:0] CODE_OUT,
  output logic              ERR_TIMEOUT,
  output logic [7:0]        RELOCK_CNT
);

  localparam int unsigned PW_W = cnt_w(PWRUP_CYCLES - 1);
  localparam int unsigned FL_W = cnt_w(LOCK_FILTER);
  localparam int unsigned TO_W = cnt_w(LOCK_TIMEOUT);
  localparam int unsigned PE_W = cnt_w(UPDATE_PERIOD - 1);
  localparam int unsigned UP_W = cnt_w(UPDATE_PULSE);

  dll_state_e        state_q, state_d;
  logic [PW_W-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [FL_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [PE_W-1:0]   per_cnt_q, per_cnt_d;
  logic [UP_W-1:0]   upd_cnt_q, upd_cnt_d;
  logic              pend_q, pend_d;
  logic              hold_q, hold_d;
  logic              diff_prev_q, diff_prev_d;
  logic              pdn_q, pdn_d;
  logic              cu_q, cu_d;
  logic              ready_q, ready_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              err_q, err_d;
  logic [7:0]        relock_q, relock_d;

  logic [1:0] sync_s;
  logic       lock_s;
  logic       diff_s;
  logic       diff_rise;
  logic       per_tc;
  logic       trigger;

  pf_lpddr3_dll_sync #(.WIDTH(2)) u_sync (
    .clk_i  (CLK),
    .srst_i (RESET),
    .async_i({DLL_LOCK, DLL_DELAY_DIFF}),
    .sync_o (sync_s)
  );

  assign lock_s    = sync_s[1];
  assign diff_s    = sync_s[0];
  assign diff_rise = diff_s & ~diff_prev_q;
  assign per_tc    = (per_cnt_q == PE_W'(UPDATE_PERIOD - 1));
  assign trigger   = per_tc | UPDATE_REQ | diff_rise;

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    filt_cnt_d  = filt_cnt_q;
    to_cnt_d    = to_cnt_q;
    per_cnt_d   = per_cnt_q;
    upd_cnt_d   = upd_cnt_q;
    pend_d      = pend_q;
    hold_d      = UPDATE_HOLD;
    diff_prev_d = diff_s;
    pdn_d       = pdn_q;
    cu_d        = cu_q;
    ready_d     = ready_q;
    code_d      = code_q;
    err_d       = err_q;
    relock_d    = relock_q;

    if (!CTRL_EN) begin
      state_d = ST_IDLE;
      pdn_d   = 1'b0;
      cu_d    = 1'b0;
      ready_d = 1'b0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_PWRUP;
          pwr_cnt_d = '0;
          err_d     = 1'b0;
          relock_d  = '0;
          code_d    = '0;
        end
        ST_PWRUP: begin
          if (pwr_cnt_q == PW_W'(PWRUP_CYCLES - 1)) begin
            state_d    = ST_WAIT_LOCK;
            pdn_d      = 1'b1;
            filt_cnt_d = '0;
            to_cnt_d   = '0;
          end else begin
            pwr_cnt_d = pwr_cnt_q + PW_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          filt_cnt_d = lock_s ? filt_cnt_q + FL_W'(1) : '0;
          to_cnt_d   = to_cnt_q + TO_W'(1);
          // Lock acceptance takes priority over a coincident timeout.
          if (lock_s && (filt_cnt_d == FL_W'(LOCK_FILTER))) begin
            state_d   = ST_UPDATE;
            cu_d      = 1'b1;
            upd_cnt_d = '0;
            pend_d    = 1'b0;
            per_cnt_d = '0;
          end else if (to_cnt_d == TO_W'(LOCK_TIMEOUT)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            pdn_d   = 1'b0;
            ready_d = 1'b0;
          end
        end
        ST_UPDATE: begin
          // READY high here means the pulse was started from TRACK.
          if (ready_q && !lock_s) begin
            state_d    = ST_WAIT_LOCK;
            cu_d       = 1'b0;
            ready_d    = 1'b0;
            pend_d     = 1'b0;
            filt_cnt_d = '0;
            to_cnt_d   = '0;
            relock_d   = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end else if (upd_cnt_q == UP_W'(UPDATE_PULSE)) begin
            state_d = ST_TRACK;
            code_d  = DLL_CODE;
            ready_d = 1'b1;
          end else begin
            upd_cnt_d = upd_cnt_q + UP_W'(1);
            if (upd_cnt_q == UP_W'(UPDATE_PULSE - 1)) cu_d = 1'b0;
          end
        end
        ST_TRACK: begin
          if (!lock_s) begin
            state_d    = ST_WAIT_LOCK;
            ready_d    = 1'b0;
            pend_d     = 1'b0;
            filt_cnt_d = '0;
            to_cnt_d   = '0;
            relock_d   = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end else begin
            per_cnt_d = per_tc ? '0 : per_cnt_q + PE_W'(1);
            pend_d    = pend_q | trigger;
            // Hold release is honoured one cycle late; assertion blocks at once.
            if (pend_q && !hold_q && !UPDATE_HOLD) begin
              state_d   = ST_UPDATE;
              cu_d      = 1'b1;
              upd_cnt_d = '0;
              pend_d    = 1'b0;
              per_cnt_d = '0;
            end
          end
        end
        ST_ERROR: begin
          pdn_d   = 1'b0;
          ready_d = 1'b0;
          err_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      pwr_cnt_q   <= '0;
      filt_cnt_q  <= '0;
      to_cnt_q    <= '0;
      per_cnt_q   <= '0;
      upd_cnt_q   <= '0;
      pend_q      <= 1'b0;
      hold_q      <= 1'b0;
      diff_prev_q <= 1'b0;
      pdn_q       <= 1'b0;
      cu_q        <= 1'b0;
      ready_q     <= 1'b0;
      code_q      <= '0;
      err_q       <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      filt_cnt_q  <= filt_cnt_d;
      to_cnt_q    <= to_cnt_d;
      per_cnt_q   <= per_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      diff_prev_q <= diff_prev_d;
      pdn_q       <= pdn_d;
      cu_q        <= cu_d;
      ready_q     <= ready_d;
      code_q      <= code_d;
      err_q       <= err_d;
      relock_q    <= relock_d;
    end
  end

  assign DLL_POWERDOWN_N = pdn_q;
  assign DLL_CODE_UPDATE = cu_q;
  assign READY           = ready_q;
  assign CODE_OUT        = code_q;
  assign ERR_TIMEOUT     = err_q;
  assign RELOCK_CNT      = relock_q;

endmodule

// File: tb/tb_pf_lpddr3_dll_ctrl.sv
// Directed bench for the DLL sequencer; inputs driven and outputs sampled on
// the falling edge, expected values hand-derived from the cycle timing.
module tb_pf_lpddr3_dll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req;
  logic       hold;
  logic       lock;
  logic       diff;
  logic [7:0] code;
  logic       pdn;
  logic       cu;
  logic       ready;
  logic [7:0] code_o;
  logic       err;
  logic [7:0] relock;

  int total = 0;
  int bad   = 0;
  int n, m, first, hi, rises, rdy_low, losses;
  logic prev;

  always #5 clk = ~clk;

  pf_lpddr3_dll_ctrl dut (
    .CLK            (clk),
    .RESET          (rst),
    .CTRL_EN        (en),
    .UPDATE_REQ     (req),
    .UPDATE_HOLD    (hold),
    .DLL_LOCK       (lock),
    .DLL_DELAY_DIFF (diff),
    .DLL_CODE       (code),
    .DLL_POWERDOWN_N(pdn),
    .DLL_CODE_UPDATE(cu),
    .READY          (ready),
    .CODE_OUT       (code_o),
    .ERR_TIMEOUT    (err),
    .RELOCK_CNT     (relock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end else begin
      $display("chk %s ok value=%0h", tag, obs);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 1'b0; hold = 1'b0;
    lock = 1'b0; diff = 1'b0; code = 8'h00;
    step(3);
    chk("rst_pdn", pdn, 0);
    chk("rst_strobe", cu, 0);
    chk("rst_ready", ready, 0);
    chk("rst_code", code_o, 0);
    chk("rst_err", err, 0);
    chk("rst_relock", relock, 0);
    rst = 1'b0;
    step(2);

    // Bring-up: one IDLE cycle plus 64 PWRUP cycles before release.
    en = 1'b1; code = 8'h5A; n = 0;
    while (!pdn && n < 200) begin step(1); n++; end
    chk("pdn_rise_cycles", n, 65);
    step(100);
    lock = 1'b1; n = 0; first = 0; hi = 0;
    while (!ready && n < 100) begin
      step(1); n++;
      if (cu) begin hi++; if (first == 0) first = n; end
    end
    // 2 sync + 8 filter samples; capture one cycle after the 4-cycle pulse.
    chk("lock_to_strobe", first, 10);
    chk("bringup_pulse_len", hi, 4);
    chk("bringup_ready", ready, 1);
    chk("bringup_code", code_o, 8'h5A);
    chk("bringup_err", err, 0);

    // Hold across the periodic terminal count, with a request during hold.
    hold = 1'b1; hi = 0;
    for (int i = 0; i < 1100; i++) begin
      req = (i == 500);
      step(1);
      if (cu) hi++;
    end
    req = 1'b0;
    chk("hold_no_strobe", hi, 0);
    hold = 1'b0; first = 0; hi = 0; rises = 0; prev = 1'b0; rdy_low = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (cu) begin hi++; if (first == 0) first = i; end
      if (cu && !prev) rises++;
      prev = cu;
      if (!ready) rdy_low++;
    end
    chk("hold_release_lat", first, 2);
    chk("hold_pulse_len", hi, 4);
    chk("hold_merged_rises", rises, 1);
    chk("ready_through_update", rdy_low, 0);

    // Drift: 2 sync cycles, 1 to register pending, 1 to enter UPDATE.
    code = 8'h61; diff = 1'b1; first = 0; hi = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (cu) begin hi++; if (first == 0) first = i; end
    end
    chk("drift_lat", first, 4);
    chk("drift_pulse_len", hi, 4);
    chk("drift_code", code_o, 8'h61);
    chk("drift_ready", ready, 1);
    diff = 1'b0;
    step(3);

    // Lock loss during a TRACK-initiated pulse; natural end would be 4 cycles.
    req = 1'b1; step(1); req = 1'b0; step(1);
    chk("req_strobe_2cyc", cu, 1);
    chk("ready_during_pulse", ready, 1);
    lock = 1'b0;
    step(3);
    chk("abort_strobe", cu, 0);
    chk("abort_ready", ready, 0);
    chk("relock_one", relock, 1);

    // Glitch: 5 high, 1 low, then high; acceptance counted from the last rise.
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      lock = (i != 5);
      step(1);
      if (cu) hi++;
    end
    lock = 1'b1; first = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (cu && first == 0) first = i;
    end
    chk("glitch_early_strobe", hi, 0);
    chk("glitch_lock_to_strobe", first, 10);
    chk("glitch_ready", ready, 1);

    // Repeated lock losses up to 300; counter saturates at 255.
    losses = 1;
    for (int i = 0; i < 299; i++) begin
      lock = 1'b0; n = 0;
      while (ready && n < 20) begin step(1); n++; end
      lock = 1'b1; n = 0;
      while (!ready && n < 60) begin step(1); n++; end
      if (!ready) begin
        chk("relock_ready", ready, 1);
        break;
      end
      losses++;
      if (losses == 200) chk("relock_200", relock, 200);
      if (losses == 255) chk("relock_255", relock, 255);
    end
    chk("loss_count", losses, 300);
    chk("relock_sat_300", relock, 255);

    // Timeout: lock held low for the whole WAIT_LOCK window.
    en = 1'b0; lock = 1'b0;
    step(2);
    chk("idle_pdn", pdn, 0);
    chk("idle_relock_held", relock, 255);
    en = 1'b1; n = 0;
    while (!pdn && n < 200) begin step(1); n++; end
    chk("pwrup_relock_clear", relock, 0);
    chk("pwrup_code_clear", code_o, 0);
    m = 0; hi = 0;
    while (!err && m < 5000) begin
      step(1); m++;
      if (cu) hi++;
    end
    chk("timeout_cycles", m, 4096);
    chk("timeout_err", err, 1);
    chk("timeout_pdn", pdn, 0);
    chk("timeout_no_strobe", hi, 0);
    en = 1'b0;
    step(1);
    chk("err_held_idle", err, 1);
    step(2);
    en = 1'b1;
    step(1);
    chk("err_clear_pwrup", err, 0);

    // Re-acquire, then reset mid-operation with CTRL_EN still high.
    lock = 1'b1; n = 0;
    while (!ready && n < 400) begin step(1); n++; end
    chk("rebringup_ready", ready, 1);
    chk("rebringup_code", code_o, 8'h61);
    rst = 1'b1;
    step(1);
    chk("midrst_pdn", pdn, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_code", code_o, 0);
    chk("midrst_strobe", cu, 0);
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
